sobel_win_sched: RTL and testbench
==================================

Name: sobel_win_sched

Overview:
Sequencing controller for the 3x3 Sobel edge datapath on the DDR3/HDMI video path. It tracks column and row position of the incoming pixel stream and drives the two line-buffer FIFO write enables, the shared FIFO read enable and the write-source select. It also generates the staged enable chain that paces the window-load, gradient, magnitude and threshold stages. The Sobel arithmetic datapath consumes these strobes; this block holds no pixel data.

Parameters:
WIDTH_P, 640, pixels per line (min 3)
LENGTH_P, 480, lines per frame (min 3)
CNT_W, 10, column/row counter width; must hold max(WIDTH_P, LENGTH_P)-1

Ports:
sys_clk  in  1  sole clock
sys_rst  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse; first pixel of the frame follows on a later cycle
pix_valid  in  1  input pixel strobe, at most one pixel per cycle
fifo_clr  out  1  one-cycle clear pulse to both line FIFOs
fifo1_wr_en  out  1  write line FIFO1 (row n-2)
fifo2_wr_en  out  1  write line FIFO2 (row n-1)
fifo1_src_sel  out  1  0: FIFO1 data from input pixel; 1: FIFO1 data from FIFO2 read output
fifo_rd_en  out  1  shared read enable, FIFO1 and FIFO2
win_shift_en  out  1  shift FIFO outputs and delayed input into window column (rd_en +1)
win_load_en  out  1  load a1..c3 window registers (rd_en +2)
grad_en  out  1  compute gx/gy; window holds 3 valid columns (rd_en +3)
mag_en  out  1  compute gxy (rd_en +4)
out_valid  out  1  thresholded pixel valid (rd_en +5)
frame_done  out  1  one-cycle pulse after the last out_valid of the frame
sched_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, col/row counters 0, pipeline shift register cleared.
- FSM states: IDLE, LINE0, LINE1, STREAM, FLUSH.
- IDLE: frame_start -> fifo_clr=1 that cycle -> LINE0. pix_valid is ignored.
- LINE0: each pix_valid drives fifo1_wr_en=1, fifo1_src_sel=0 the same cycle. col==WIDTH_P-1 wraps col to 0, row to 1 -> LINE1.
- LINE1: each pix_valid drives fifo2_wr_en=1. Wrap -> STREAM with row=2.
- STREAM: each pix_valid drives fifo_rd_en=1 the same cycle. One cycle later:
  - fifo1_wr_en=1 with fifo1_src_sel=1 (row n-1 moves into FIFO1);
  - fifo2_wr_en=1 (the 1-cycle-delayed input pixel is written).
- Last pixel of row LENGTH_P-1 -> FLUSH.
- Enable chain is a 5-bit shift of fifo_rd_en. grad_en is additionally qualified by rd_col>=2, where rd_col counts reads within the line and resets at each line wrap. Yields WIDTH_P-2 results per line and (WIDTH_P-2)*(LENGTH_P-2) per frame.
- FLUSH: no writes. Waits until the shift register is empty, then frame_done=1 for one cycle -> IDLE.
- frame_start in any non-IDLE state aborts: counters 0, shift register cleared, fifo_clr=1 -> LINE0. Abort takes priority over a coincident pix_valid, which is dropped.
- pix_valid gaps are allowed; counters and the chain advance only on strobes, and the chain shifts every cycle.
- Reset mid-frame returns to the reset state immediately. No frame_done is issued.

Optional Feature:
SOBEL_SCHED_ERR_EN:
- Defined: sched_err is set by pix_valid in IDLE or FLUSH, and by frame_start during STREAM before the last line completes. It clears only on sys_rst.
- Undefined: sched_err is tied 0; such pixels are silently ignored and behaviour is otherwise identical.

Decomposition:
- Shared package sobel_pkg: FSM state encoding (3-bit localparams), pipeline depth constant PIPE_DEPTH=5, THRESHOLD/BLACK/WHITE constants shared with the datapath.
- One natural sub-module, sobel_pos_cnt: the column/row counter pair with wrap and last-pixel flags, instantiated once.

Test Plan:
All tests use WIDTH_P=8, LENGTH_P=5.
- Full frame, pix_valid every cycle: 8 fifo1 writes with sel=0, 8 fifo2 writes, 24 fifo_rd_en, 18 out_valid, each out_valid exactly 5 cycles after its fifo_rd_en; single frame_done.
- Same frame with pix_valid on alternate cycles: identical counts; out_valid still rd_en+5.
- Reset and idle: sys_rst high 3 cycles, then pix_valid pulses in IDLE -> no FIFO strobes; sched_err=1 only with SOBEL_SCHED_ERR_EN.
- frame_start mid-row 3: fifo_clr pulses; the next 8 pixels drive fifo1_wr_en with sel=0; no frame_done from the aborted frame.
- Boundary: grad_en absent on the first 2 reads of every line; fifo1_wr_en with sel=1 occurs exactly 1 cycle after each fifo_rd_en.
- sys_rst asserted during FLUSH -> frame_done never pulses; all outputs 0 the next cycle.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window scheduler and its arithmetic datapath.
// State encoding, enable-chain depth and output pixel levels.
package sobel_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LINE0  = 3'd1;
   localparam logic [2:0] ST_LINE1  = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_FLUSH  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_LINE0  = ST_LINE0,
      S_LINE1  = ST_LINE1,
      S_STREAM = ST_STREAM,
      S_FLUSH  = ST_FLUSH
   } sched_state_e;

   localparam int PIPE_DEPTH = 5;

   localparam logic [7:0] THRESHOLD = 8'd100;
   localparam logic [7:0] BLACK     = 8'h00;
   localparam logic [7:0] WHITE     = 8'hFF;

endpackage

// File: rtl/sobel_pos_cnt.sv
// Column/row position of the incoming pixel stream, advancing once per accepted pixel.
// Exposes the current column plus end-of-line and end-of-frame flags.
module sobel_pos_cnt #(
   parameter int WIDTH_P  = 640,
   parameter int LENGTH_P = 480,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] col,
   output logic             col_last,
   output logic             frame_last
);

   logic [CNT_W-1:0] col_reg;
   logic [CNT_W-1:0] row_reg;

   assign col        = col_reg;
   assign col_last   = (col_reg == CNT_W'(WIDTH_P - 1));
   assign frame_last = col_last && (row_reg == CNT_W'(LENGTH_P - 1));

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (adv) begin
         if (col_last) begin
            col_reg <= '0;
            row_reg <= frame_last ? '0 : row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sobel_win_sched.sv
// Sequencing controller for the 3x3 Sobel window: line-FIFO strobes and stage enable chain.
// Optional sticky protocol-error flag enabled by defining SOBEL_SCHED_ERR_EN.
module sobel_win_sched
   import sobel_pkg::*;
#(
   parameter int WIDTH_P  = 640,
   parameter int LENGTH_P = 480,
   parameter int CNT_W    = 10
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic frame_start,
   input  logic pix_valid,
   output logic fifo_clr,
   output logic fifo1_wr_en,
   output logic fifo2_wr_en,
   output logic fifo1_src_sel,
   output logic fifo_rd_en,
   output logic win_shift_en,
   output logic win_load_en,
   output logic grad_en,
   output logic mag_en,
   output logic out_valid,
   output logic frame_done,
   output logic sched_err
);

   sched_state_e          state_reg;
   logic [PIPE_DEPTH-1:0] rd_pipe_reg;
   logic [PIPE_DEPTH-1:0] res_pipe_reg;
   logic                  wr_dly_reg;
   logic                  frame_done_reg;

   logic [CNT_W-1:0] col;
   logic             col_last;
   logic             frame_last;

   logic accept;
   logic line0_wr;
   logic line1_wr;
   logic rd_now;
   logic res_now;
   logic cnt_adv;

   // A coincident frame_start wins over the pixel, so the pixel is never accepted.
   assign accept   = pix_valid && !frame_start && !sys_rst;
   assign line0_wr = accept && (state_reg == S_LINE0);
   assign line1_wr = accept && (state_reg == S_LINE1);
   assign rd_now   = accept && (state_reg == S_STREAM);
   assign res_now  = rd_now && (col >= CNT_W'(2));
   assign cnt_adv  = line0_wr || line1_wr || rd_now;

   sobel_pos_cnt #(
      .WIDTH_P  (WIDTH_P),
      .LENGTH_P (LENGTH_P),
      .CNT_W    (CNT_W)
   ) u_pos_cnt (
      .clk        (sys_clk),
      .srst       (sys_rst),
      .clr        (frame_start),
      .adv        (cnt_adv),
      .col        (col),
      .col_last   (col_last),
      .frame_last (frame_last)
   );

   // Row n-1 recirculates from FIFO2 into FIFO1 one cycle after the read that exposed it.
   assign fifo_clr      = frame_start && !sys_rst;
   assign fifo1_wr_en   = line0_wr || wr_dly_reg;
   assign fifo1_src_sel = wr_dly_reg;
   assign fifo2_wr_en   = line1_wr || wr_dly_reg;
   assign fifo_rd_en    = rd_now;

   assign win_shift_en = rd_pipe_reg[0];
   assign win_load_en  = rd_pipe_reg[1];
   assign grad_en      = res_pipe_reg[2];
   assign mag_en       = res_pipe_reg[3];
   assign out_valid    = res_pipe_reg[PIPE_DEPTH-1];
   assign frame_done   = frame_done_reg;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg      <= S_IDLE;
         rd_pipe_reg    <= '0;
         res_pipe_reg   <= '0;
         wr_dly_reg     <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         rd_pipe_reg    <= {rd_pipe_reg[PIPE_DEPTH-2:0], rd_now};
         res_pipe_reg   <= {res_pipe_reg[PIPE_DEPTH-2:0], res_now};
         wr_dly_reg     <= rd_now;
         frame_done_reg <= 1'b0;
         if (frame_start) begin
            rd_pipe_reg  <= '0;
            res_pipe_reg <= '0;
            wr_dly_reg   <= 1'b0;
            state_reg    <= S_LINE0;
         end else begin
            case (state_reg)
               S_IDLE: state_reg <= S_IDLE;
               S_LINE0: if (pix_valid && col_last) state_reg <= S_LINE1;
               S_LINE1: if (pix_valid && col_last) state_reg <= S_STREAM;
               S_STREAM: if (pix_valid && frame_last) state_reg <= S_FLUSH;
               S_FLUSH: begin
                  if ((rd_pipe_reg == '0) && !wr_dly_reg) begin
                     frame_done_reg <= 1'b1;
                     state_reg      <= S_IDLE;
                  end
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

`ifdef SOBEL_SCHED_ERR_EN
   logic err_reg;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         err_reg <= 1'b0;
      end else if ((pix_valid && ((state_reg == S_IDLE) || (state_reg == S_FLUSH))) ||
                   (frame_start && (state_reg == S_STREAM))) begin
         err_reg <= 1'b1;
      end
   end

   assign sched_err = err_reg;
`else
   assign sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_win_sched.sv
// Self-checking bench for sobel_win_sched (WIDTH_P=8, LENGTH_P=5) against a pixel-indexed model.
// Honours SOBEL_SCHED_ERR_EN when choosing the expected sched_err value.
module tb_sobel_win_sched;

   localparam int W    = 8;
   localparam int L    = 5;
   localparam int MAXC = 600;

`ifdef SOBEL_SCHED_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic frame_start = 1'b0;
   logic pix_valid = 1'b0;
   logic fifo_clr, fifo1_wr_en, fifo2_wr_en, fifo1_src_sel, fifo_rd_en;
   logic win_shift_en, win_load_en, grad_en, mag_en, out_valid, frame_done, sched_err;

   int checks = 0;
   int errors = 0;

   sobel_win_sched #(.WIDTH_P(W), .LENGTH_P(L), .CNT_W(4)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .frame_start   (frame_start),
      .pix_valid     (pix_valid),
      .fifo_clr      (fifo_clr),
      .fifo1_wr_en   (fifo1_wr_en),
      .fifo2_wr_en   (fifo2_wr_en),
      .fifo1_src_sel (fifo1_src_sel),
      .fifo_rd_en    (fifo_rd_en),
      .win_shift_en  (win_shift_en),
      .win_load_en   (win_load_en),
      .grad_en       (grad_en),
      .mag_en        (mag_en),
      .out_valid     (out_valid),
      .frame_done    (frame_done),
      .sched_err     (sched_err)
   );

   always #5 sys_clk = ~sys_clk;

   // {clr,f1,f2,sel,rd,sh,ld,gr,mg,ov,done,err}
   logic [11:0] outs;
   assign outs = {fifo_clr, fifo1_wr_en, fifo2_wr_en, fifo1_src_sel, fifo_rd_en, win_shift_en,
                  win_load_en, grad_en, mag_en, out_valid, frame_done, sched_err};

   logic        rec_on = 1'b0;
   logic        rec_clr = 1'b0;
   int          rec_n = 0;
   logic [2:0]  h_in [MAXC];   // {rst,fs,pv}
   logic [11:0] h_out [MAXC];

   always @(negedge sys_clk) begin
      if (rec_clr) begin
         rec_n <= 0;
      end else if (rec_on && rec_n < MAXC) begin
         h_in[rec_n]  <= {sys_rst, frame_start, pix_valid};
         h_out[rec_n] <= outs;
         rec_n        <= rec_n + 1;
      end
   end

   // Expected {clr,f1,f2,rd,sh,ld,gr,mg,ov} per cycle, plus expected src_sel on FIFO1 writes.
   logic [8:0] e_vec [MAXC];
   logic       e_sel [MAXC];
   int         n_done_exp;
   int         last_ov;

   task automatic build_model();
      int k;
      int row;
      int col;
      logic in_frame;
      k = 0;
      in_frame = 1'b0;
      n_done_exp = 0;
      last_ov = -1;
      for (int c = 0; c < MAXC; c++) begin
         e_vec[c] = '0;
         e_sel[c] = 1'b0;
      end
      for (int c = 0; c < rec_n; c++) begin
         if (h_in[c][2]) begin
            in_frame = 1'b0;
         end else if (h_in[c][1]) begin
            e_vec[c][8] = 1'b1;
            in_frame = 1'b1;
            k = 0;
         end else if (h_in[c][0] && in_frame && c + 5 < MAXC) begin
            row = k / W;
            col = k % W;
            if (row == 0) begin
               e_vec[c][7] = 1'b1;
            end else if (row == 1) begin
               e_vec[c][6] = 1'b1;
            end else begin
               e_vec[c][5]   = 1'b1;
               e_vec[c+1][7] = 1'b1;
               e_sel[c+1]    = 1'b1;
               e_vec[c+1][6] = 1'b1;
               e_vec[c+1][4] = 1'b1;
               e_vec[c+2][3] = 1'b1;
               if (col >= 2) begin
                  e_vec[c+3][2] = 1'b1;
                  e_vec[c+4][1] = 1'b1;
                  e_vec[c+5][0] = 1'b1;
                  last_ov = c + 5;
               end
            end
            k++;
            if (k == W * L) begin
               in_frame = 1'b0;
               n_done_exp++;
            end
         end
      end
   endtask

   task automatic start_rec();
      rec_on = 1'b0;
      rec_clr = 1'b1;
      @(negedge sys_clk);
      #1 rec_clr = 1'b0;
      rec_on = 1'b1;
   endtask

   task automatic stop_rec();
      @(negedge sys_clk);
      #1 rec_on = 1'b0;
   endtask

   task automatic pulse_fs();
      @(posedge sys_clk);
      #1 frame_start = 1'b1;
      pix_valid = 1'b0;
      @(posedge sys_clk);
      #1 frame_start = 1'b0;
   endtask

   // mode 0: every cycle, 1: alternate cycles, 2: random 0..2 idle cycles between pixels
   task automatic drive_pixels(input int n, input int mode);
      int gaps;
      for (int i = 0; i < n; i++) begin
         gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
         for (int g = 0; g < gaps; g++) begin
            @(posedge sys_clk);
            #1 pix_valid = 1'b0;
         end
         @(posedge sys_clk);
         #1 pix_valid = 1'b1;
      end
      @(posedge sys_clk);
      #1 pix_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         #1 pix_valid = 1'b0;
      end
   endtask

   task automatic test_reset_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         checks++;
         if (outs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outs got %b exp 000000000000", outs);
         end
      end
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge sys_clk);
         #1 pix_valid = 1'b1;
         @(negedge sys_clk);
         checks++;
         if ({fifo_clr, fifo1_wr_en, fifo2_wr_en, fifo_rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_strobes got %b exp 0000",
                     {fifo_clr, fifo1_wr_en, fifo2_wr_en, fifo_rd_en});
         end
         @(posedge sys_clk);
         #1 pix_valid = 1'b0;
      end
      @(negedge sys_clk);
      checks++;
      if (sched_err !== ERR_ON) begin
         errors++;
         $display("FAIL idle_sched_err got %b exp %b", sched_err, ERR_ON);
      end
      @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (sched_err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared got %b exp 0", sched_err);
      end
   endtask

   task automatic test_frames();
      int n_done, done_cyc, n_rd, n_ov, n_f1s0, n_f2o;
      logic [8:0] act;
      for (int m = 0; m < 3; m++) begin
         start_rec();
         pulse_fs();
         drive_pixels(W * L, m);
         idle_cycles(20);
         stop_rec();
         build_model();
         n_done = 0; done_cyc = -1; n_rd = 0; n_ov = 0; n_f1s0 = 0; n_f2o = 0;
         for (int c = 0; c < rec_n; c++) begin
            act = {h_out[c][11:9], h_out[c][7:2]};
            checks++;
            if (act !== e_vec[c]) begin
               errors++;
               $display("FAIL frame_m%0d_strobes cyc %0d got %b exp %b", m, c, act, e_vec[c]);
            end
            if (e_vec[c][7]) begin
               checks++;
               if (h_out[c][8] !== e_sel[c]) begin
                  errors++;
                  $display("FAIL frame_m%0d_src_sel cyc %0d got %b exp %b",
                           m, c, h_out[c][8], e_sel[c]);
               end
            end
            if (h_out[c][1]) begin n_done++; done_cyc = c; end
            if (h_out[c][7]) n_rd++;
            if (h_out[c][2]) n_ov++;
            if (h_out[c][10] && !h_out[c][8]) n_f1s0++;
            if (h_out[c][9] && !h_out[c][10]) n_f2o++;
         end
         checks++;
         if (n_rd != (L - 2) * W || n_ov != (L - 2) * (W - 2) || n_f1s0 != W || n_f2o != W) begin
            errors++;
            $display("FAIL frame_m%0d_counts got rd=%0d ov=%0d f1s0=%0d f2=%0d exp rd=%0d ov=%0d f1s0=%0d f2=%0d",
                     m, n_rd, n_ov, n_f1s0, n_f2o, (L - 2) * W, (L - 2) * (W - 2), W, W);
         end
         checks++;
         if (n_done != 1 || n_done_exp != 1 || done_cyc <= last_ov || done_cyc > last_ov + 3) begin
            errors++;
            $display("FAIL frame_m%0d_done got n=%0d at %0d exp n=1 in (%0d,%0d]",
                     m, n_done, done_cyc, last_ov, last_ov + 3);
         end
         checks++;
         if (sched_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_m%0d_err got %b exp 0", m, sched_err);
         end
      end
   endtask

   task automatic test_abort();
      int n_done, n_f1s0;
      logic [3:0] act;
      logic [3:0] expv;
      start_rec();
      pulse_fs();
      drive_pixels(3 * W + 3, 2);
      idle_cycles(8);
      pulse_fs();
      drive_pixels(W * L, 2);
      idle_cycles(20);
      stop_rec();
      build_model();
      n_done = 0;
      n_f1s0 = 0;
      for (int c = 0; c < rec_n; c++) begin
         act  = {h_out[c][11], h_out[c][10], h_out[c][8] & h_out[c][10], h_out[c][7]};
         expv = {e_vec[c][8], e_vec[c][7], e_sel[c] & e_vec[c][7], e_vec[c][5]};
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL abort_clr_f1_sel_rd cyc %0d got %b exp %b", c, act, expv);
         end
         if (h_out[c][1]) n_done++;
         if (h_out[c][10] && !h_out[c][8]) n_f1s0++;
      end
      checks++;
      if (n_done != n_done_exp || n_f1s0 != 2 * W) begin
         errors++;
         $display("FAIL abort_done_f1 got done=%0d f1s0=%0d exp done=%0d f1s0=%0d",
                  n_done, n_f1s0, n_done_exp, 2 * W);
      end
      checks++;
      if (sched_err !== ERR_ON) begin
         errors++;
         $display("FAIL abort_sched_err got %b exp %b", sched_err, ERR_ON);
      end
   endtask

   task automatic test_flush_reset();
      int n_done;
      pulse_fs();
      drive_pixels(W * L, 0);
      @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (outs !== 12'h000) begin
         errors++;
         $display("FAIL flush_reset_outs got %b exp 000000000000", outs);
      end
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge sys_clk);
         if (frame_done) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL flush_reset_done got %0d exp 0", n_done);
      end
   endtask

   initial begin
      test_reset_idle();
      test_frames();
      test_abort();
      test_flush_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
